// File: rtl/ram_mem_param_if.sv
// Access bus for ram_mem_param: request side (master) and memory side (slave).
interface ram_mem_param_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic              en;
  logic              we;
  logic [ADDR_W-1:0] address;
  logic [WIDTH-1:0]  wdata;
  logic [WIDTH/8-1:0] be;
  logic              clr;
  logic [WIDTH-1:0]  rdata;
  logic              rvalid;
  logic              busy;

  modport master (
    output en, we, address, wdata, be, clr,
    input  rdata, rvalid, busy
  );

  modport slave (
    input  en, we, address, wdata, be, clr,
    output rdata, rvalid, busy
  );
endinterface

// File: rtl/ram_mem_param.sv
// Single-port word RAM with byte enables, registered reads and a
// self-timed clear sequence that zeroes every word after reset or on request.
module ram_mem_param #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic            CLK,
  input  logic            RST,
  ram_mem_param_if.slave  bus
);

  localparam int NB = WIDTH / 8;
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);

  typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_next;

  logic [WIDTH-1:0]  mem [0:DEPTH-1];

  logic              acc, wr_acc, rd_acc, in_range;
  logic [WIDTH-1:0]  rdata_p1;
  logic              vld_p1;

  // Accesses are only honoured in IDLE and lose to a simultaneous clear.
  assign acc      = (state == IDLE) && !bus.clr && bus.en;
  assign wr_acc   = acc && bus.we;
  assign rd_acc   = acc && !bus.we;
  assign in_range = {1'b0, bus.address} < DEPTH_EXT;

  // State and clear pointer; reset restarts the clear from word 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_next;
      clr_ptr <= clr_ptr_next;
    end
  end

  // Next-state: walk the clear pointer to the last word, then go idle.
  always_comb begin
    state_next   = state;
    clr_ptr_next = clr_ptr;
    case (state)
      CLEAR: begin
        if (clr_ptr == LAST_WORD) begin
          state_next   = IDLE;
          clr_ptr_next = '0;
        end else begin
          clr_ptr_next = clr_ptr + ADDR_W'(1);
        end
      end
      IDLE: begin
        if (bus.clr) begin
          state_next   = CLEAR;
          clr_ptr_next = '0;
        end
      end
      default: begin
        state_next   = CLEAR;
        clr_ptr_next = '0;
      end
    endcase
  end

  // Storage array: cleared word by word, otherwise byte-masked writes.
  always_ff @(posedge CLK) begin
    if (state == CLEAR) begin
      mem[clr_ptr] <= '0;
    end else if (wr_acc && in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.be[i]) mem[bus.address][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
    end
  end

  // Read stage p1: one-cycle latency, out-of-range reads return zero,
  // and the data register holds between reads.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      vld_p1 <= rd_acc;
      if (rd_acc) rdata_p1 <= in_range ? mem[bus.address] : '0;
    end
  end

  assign bus.rdata  = rdata_p1;
  assign bus.rvalid = vld_p1;
  assign bus.busy   = (state == CLEAR);

endmodule

// File: tb/tb_ram_mem_param.sv
// Self-checking bench for ram_mem_param: default instance plus a DEPTH=20 instance.
module tb_ram_mem_param;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  always #5 CLK = ~CLK;

  ram_mem_param_if #(.WIDTH(32), .ADDR_W(5)) bus   ();
  ram_mem_param_if #(.WIDTH(32), .ADDR_W(5)) bus20 ();

  ram_mem_param #(.WIDTH(32), .DEPTH(32), .ADDR_W(5)) dut (
    .CLK (CLK), .RST (RST), .bus (bus)
  );

  ram_mem_param #(.WIDTH(32), .DEPTH(20), .ADDR_W(5)) dut20 (
    .CLK (CLK), .RST (RST), .bus (bus20)
  );

  // Reference model: word arrays indexed by address, plus depth per instance.
  logic [31:0] m32 [32];
  logic [31:0] m20 [32];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs;
    bus.en = 0; bus.we = 0; bus.clr = 0; bus.address = '0; bus.wdata = '0; bus.be = '0;
    bus20.en = 0; bus20.we = 0; bus20.clr = 0; bus20.address = '0; bus20.wdata = '0; bus20.be = '0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic clear_model32;
    for (int i = 0; i < 32; i++) m32[i] = '0;
  endtask

  task automatic clear_model20;
    for (int i = 0; i < 32; i++) m20[i] = '0;
  endtask

  task automatic write32(input int a, input logic [31:0] d, input logic [3:0] be);
    bus.en = 1; bus.we = 1; bus.address = a[4:0]; bus.wdata = d; bus.be = be;
    tick();
    bus.en = 0; bus.we = 0;
    m32[a] = merge(m32[a], d, be);
  endtask

  task automatic test_reset;
    idle_inputs();
    #1 RST = 1;
    #1;
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy got=%b exp=1", bus.busy); end
    n_checks++; if (bus.rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got=%b exp=0", bus.rvalid); end
    n_checks++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", bus.rdata); end
    tick(); tick();
    RST = 0;
  endtask

  task automatic test_clear_zero;
    int cnt, cnt20;
    cnt = 0; cnt20 = 0;
    while ((bus.busy || bus20.busy) && cnt < 100) begin
      if (bus.busy) cnt++;
      if (bus20.busy) cnt20++;
      tick();
    end
    n_checks++; if (cnt !== 32) begin n_fail++; $display("FAIL clear_len got=%0d exp=32", cnt); end
    n_checks++; if (cnt20 !== 20) begin n_fail++; $display("FAIL clear_len20 got=%0d exp=20", cnt20); end
    clear_model32(); clear_model20();
    for (int a = 0; a < 32; a++) begin
      bus.en = 1; bus.we = 0; bus.address = a[4:0];
      tick();
      n_checks++;
      if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h0) begin
        n_fail++; $display("FAIL zero_read a=%0d got=%b/%h exp=1/00000000", a, bus.rvalid, bus.rdata);
      end
    end
    bus.en = 0;
    tick();
  endtask

  task automatic test_byte_write;
    write32(5, 32'hDEADBEEF, 4'b1111);
    n_checks++; if (bus.rvalid !== 1'b0) begin n_fail++; $display("FAIL write_no_rvalid got=%b exp=0", bus.rvalid); end
    write32(5, 32'h000000AA, 4'b0001);
    write32(5, 32'h11223344, 4'b0000);
    bus.en = 1; bus.we = 0; bus.address = 5;
    tick();
    bus.en = 0;
    n_checks++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== 32'hDEADBEAA) begin
      n_fail++; $display("FAIL byte_write got=%b/%h exp=1/deadbeaa", bus.rvalid, bus.rdata);
    end
    tick();
    n_checks++;
    if (bus.rvalid !== 1'b0 || bus.rdata !== 32'hDEADBEAA) begin
      n_fail++; $display("FAIL rdata_hold got=%b/%h exp=0/deadbeaa", bus.rvalid, bus.rdata);
    end
  endtask

  task automatic test_back_to_back;
    int run;
    for (int a = 0; a <= 10; a++) write32(a, 32'(3*a), 4'b1111);
    run = 0;
    for (int a = 0; a <= 10; a++) begin
      bus.en = 1; bus.we = 0; bus.address = a[4:0];
      tick();
      if (bus.rvalid === 1'b1) run++;
      n_checks++;
      if (bus.rdata !== 32'(3*a)) begin
        n_fail++; $display("FAIL b2b_data a=%0d got=%h exp=%h", a, bus.rdata, 32'(3*a));
      end
    end
    bus.en = 0;
    tick();
    n_checks++; if (run !== 11) begin n_fail++; $display("FAIL b2b_rvalid_run got=%0d exp=11", run); end
  endtask

  task automatic test_clr_priority;
    int cnt;
    write32(3, 32'hCAFEF00D, 4'b1111);
    bus.clr = 1; bus.en = 1; bus.we = 1; bus.address = 2; bus.wdata = 32'h12345678; bus.be = 4'hF;
    tick();
    bus.clr = 0;
    clear_model32();
    cnt = 0;
    // Keep pushing writes during the clear; they must all be ignored.
    bus.address = 3; bus.wdata = 32'hFFFFFFFF;
    while (bus.busy && cnt < 100) begin cnt++; tick(); end
    bus.en = 0; bus.we = 0;
    n_checks++; if (cnt !== 32) begin n_fail++; $display("FAIL clr_busy_len got=%0d exp=32", cnt); end
    for (int a = 2; a <= 3; a++) begin
      bus.en = 1; bus.we = 0; bus.address = a[4:0];
      tick();
      n_checks++;
      if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h0) begin
        n_fail++; $display("FAIL clr_dropped a=%0d got=%b/%h exp=1/00000000", a, bus.rvalid, bus.rdata);
      end
    end
    bus.en = 0;
    tick();
  endtask

  task automatic test_reset_mid_clear;
    int cnt, stale;
    write32(20, 32'hA5A5A5A5, 4'b1111);
    bus.clr = 1;
    tick();
    bus.clr = 0;
    for (int i = 0; i < 10; i++) tick();
    RST = 1;
    bus.en = 1; bus.we = 0; bus.address = 20;
    tick();
    RST = 0;
    cnt = 0; stale = 0;
    while (bus.busy && cnt < 100) begin
      cnt++; tick();
      if (bus.rvalid !== 1'b0) stale++;
    end
    bus.en = 0;
    clear_model32(); clear_model20();
    n_checks++; if (cnt !== 32) begin n_fail++; $display("FAIL rst_mid_clear_len got=%0d exp=32", cnt); end
    n_checks++; if (stale !== 0) begin n_fail++; $display("FAIL rst_mid_clear_rvalid got=%0d exp=0", stale); end
    bus.en = 1; bus.address = 20;
    tick();
    bus.en = 0;
    n_checks++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h0) begin
      n_fail++; $display("FAIL rst_reclear got=%b/%h exp=1/00000000", bus.rvalid, bus.rdata);
    end
    while (bus20.busy) tick();
  endtask

  task automatic test_reset_mid_read;
    int cnt;
    write32(7, 32'h0BADF00D, 4'b1111);
    bus.en = 1; bus.we = 0; bus.address = 7;
    tick();
    n_checks++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h0BADF00D) begin
      n_fail++; $display("FAIL pre_rst_read got=%b/%h exp=1/0badf00d", bus.rvalid, bus.rdata);
    end
    #2 RST = 1;
    #1;
    n_checks++;
    if (bus.rvalid !== 1'b0 || bus.rdata !== 32'h0 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL async_rst got=%b/%h/%b exp=0/00000000/1", bus.rvalid, bus.rdata, bus.busy);
    end
    tick();
    RST = 0;
    bus.en = 0;
    cnt = 0;
    while (bus.busy && cnt < 100) begin cnt++; tick(); end
    clear_model32(); clear_model20();
    n_checks++; if (cnt !== 32) begin n_fail++; $display("FAIL rst_mid_read_len got=%0d exp=32", cnt); end
  endtask

  task automatic test_small_depth;
    int cnt;
    bus20.en = 1; bus20.we = 1; bus20.address = 25; bus20.wdata = 32'hFFFFFFFF; bus20.be = 4'hF;
    tick();
    bus20.address = 19; bus20.wdata = 32'h13579BDF;
    tick();
    m20[19] = 32'h13579BDF;
    bus20.we = 0; bus20.address = 25;
    tick();
    n_checks++;
    if (bus20.rvalid !== 1'b1 || bus20.rdata !== 32'h0) begin
      n_fail++; $display("FAIL oor_read20 got=%b/%h exp=1/00000000", bus20.rvalid, bus20.rdata);
    end
    bus20.address = 19;
    tick();
    bus20.en = 0;
    n_checks++;
    if (bus20.rvalid !== 1'b1 || bus20.rdata !== m20[19]) begin
      n_fail++; $display("FAIL last_word20 got=%b/%h exp=1/%h", bus20.rvalid, bus20.rdata, m20[19]);
    end
    bus20.clr = 1;
    tick();
    bus20.clr = 0;
    cnt = 0;
    while (bus20.busy && cnt < 100) begin cnt++; tick(); end
    clear_model20();
    n_checks++; if (cnt !== 20) begin n_fail++; $display("FAIL clr_len20 got=%0d exp=20", cnt); end
    bus20.en = 1; bus20.address = 19;
    tick();
    bus20.en = 0;
    n_checks++;
    if (bus20.rvalid !== 1'b1 || bus20.rdata !== 32'h0) begin
      n_fail++; $display("FAIL clr20_read got=%b/%h exp=1/00000000", bus20.rvalid, bus20.rdata);
    end
  endtask

  task automatic test_random;
    logic [31:0] last32, last20, d, d2;
    logic [3:0]  b, b2;
    int op, a, op2, a2;
    bit rd32, rd20;
    // Start each instance with a read of a known address so the hold value is defined.
    last32 = m32[0]; last20 = m20[0];
    bus.en = 1; bus.we = 0; bus.address = 0;
    bus20.en = 1; bus20.we = 0; bus20.address = 0;
    tick();
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 3); a = $urandom_range(0, 31); d = $urandom; b = 4'($urandom);
      op2 = $urandom_range(0, 3); a2 = $urandom_range(0, 31); d2 = $urandom; b2 = 4'($urandom);
      bus.en = (op != 0); bus.we = (op == 1); bus.address = a[4:0]; bus.wdata = d; bus.be = b;
      bus20.en = (op2 != 0); bus20.we = (op2 == 1); bus20.address = a2[4:0]; bus20.wdata = d2; bus20.be = b2;
      rd32 = (op >= 2); rd20 = (op2 >= 2);
      if (rd32) last32 = m32[a];
      if (rd20) last20 = (a2 < 20) ? m20[a2] : 32'h0;
      tick();
      if (op == 1) m32[a] = merge(m32[a], d, b);
      if (op2 == 1 && a2 < 20) m20[a2] = merge(m20[a2], d2, b2);
      n_checks++;
      if (bus.rvalid !== rd32 || bus.rdata !== last32) begin
        n_fail++; $display("FAIL rand32 n=%0d a=%0d got=%b/%h exp=%b/%h", n, a, bus.rvalid, bus.rdata, rd32, last32);
      end
      n_checks++;
      if (bus20.rvalid !== rd20 || bus20.rdata !== last20) begin
        n_fail++; $display("FAIL rand20 n=%0d a=%0d got=%b/%h exp=%b/%h", n, a2, bus20.rvalid, bus20.rdata, rd20, last20);
      end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    clear_model32(); clear_model20();
    test_reset();
    test_clear_zero();
    test_byte_write();
    test_back_to_back();
    test_clr_priority();
    test_reset_mid_clear();
    test_reset_mid_read();
    test_small_depth();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_mem_param.md
RAM_MEM_PARAM -- requirements
Module: ram_mem_param

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 32, number of words; legal range 2..2**ADDR_W.
REQ-003 Parameter ADDR_W, default 5, address width in bits.
REQ-004 Port CLK  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 Port RST  input  1  reset; asynchronous and active-high.
REQ-006 Port en  input  1  access request strobe, sampled each rising edge.
REQ-007 Port we  input  1  access type qualifier: 1 = write, 0 = read; meaningful only with en=1.
REQ-008 Port address  input  ADDR_W  word address of the access.
REQ-009 Port wdata  input  WIDTH  write data.
REQ-010 Port be  input  WIDTH/8  byte enables; bit i covers wdata[8i+7:8i].
REQ-011 Port clr  input  1  request a full-memory clear.
REQ-012 Port rdata  output  WIDTH  registered read data.
REQ-013 Port rvalid  output  1  one-cycle pulse; rdata is valid while it is high.
REQ-014 Port busy  output  1  high while the clear sequence runs; accesses are not accepted.

Function
REQ-015 The block SHALL implement a two-state FSM: CLEAR and IDLE.
REQ-016 In CLEAR, the block SHALL write 0 to word clr_ptr each cycle and increment clr_ptr by 1, starting at 0.
REQ-017 The cycle that clears word DEPTH-1 SHALL be the last CLEAR cycle; the FSM SHALL then enter IDLE.
REQ-018 busy SHALL equal (state==CLEAR); a clear SHALL therefore hold busy high for exactly DEPTH cycles.
REQ-019 In IDLE, clr=1 SHALL take priority over en; the FSM SHALL enter CLEAR with clr_ptr=0, and any simultaneous access SHALL be dropped.
REQ-020 While busy=1, en, we, clr and wdata SHALL be ignored, and rvalid SHALL stay 0.
REQ-021 Write (IDLE, en=1, we=1, address<DEPTH): each byte i with be[i]=1 SHALL be updated at the edge; bytes with be[i]=0 SHALL keep their value.
REQ-022 Write with be all-zero SHALL leave memory unchanged; no rvalid SHALL be produced for a write.
REQ-023 Read (IDLE, en=1, we=0): rdata SHALL present mem[address] and rvalid SHALL be 1 in the cycle after the sampling edge (latency 1).
REQ-024 Back-to-back reads on consecutive cycles SHALL be supported at one result per cycle, with rvalid held high continuously.
REQ-025 rdata SHALL hold its last value while rvalid=0.
REQ-026 Address >= DEPTH: a write SHALL be discarded; a read SHALL return 0 with rvalid=1.
REQ-027 A read immediately following a write to the same address SHALL return the newly written data.

Reset
REQ-028 RST=1 SHALL immediately force rdata=0, rvalid=0, state=CLEAR, clr_ptr=0, busy=1, independent of CLK.
REQ-029 Memory contents SHALL NOT be reset directly; after RST deasserts, they SHALL be zeroed by the CLEAR sequence.
REQ-030 RST asserted mid-CLEAR or mid-read SHALL abort the operation; the clear SHALL restart from word 0, and no stale rvalid SHALL be produced.

Verification
REQ-031 Release RST, count cycles with busy=1 -> exactly 32 (defaults); then read addresses 0..31 -> every rdata=0x00000000 with rvalid=1.
REQ-032 Write 0xDEADBEEF to address 5 with be=4'b1111, then be=4'b0001 with wdata=0x000000AA, then read 5 -> rdata=0xDEADBEAA one cycle after the read request.
REQ-033 Read addresses 0..10 on consecutive cycles after writing data=address*3 -> rvalid high for 11 consecutive cycles and rdata sequence 0,3,6,...,30.
REQ-034 Pulse clr with en=1, we=1, address=2, wdata=0x12345678 in the same cycle -> write dropped, busy high 32 cycles, then read 2 -> 0.
REQ-035 Assert RST for 1 cycle at clear cycle 10 -> busy stays high 32 more cycles after release, and rvalid stays 0 throughout.
REQ-036 Instance with DEPTH=20, ADDR_W=5: write 0xFFFFFFFF to address 25, then read 25 -> rdata=0 with rvalid=1; after clear, busy lasts 20 cycles.
